// File: rtl/treeval_cmd_arbiter.sv
// Session arbiter sharing one treeval command path among N_REQ requesters.
// Define TREEVAL_ARB_TIMEOUT_EN to enable the RUN-to-result watchdog.
module treeval_cmd_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned W_REWARD       = 10,
  parameter int unsigned W_ACTION       = 3,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned OwnerW        = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [64*N_REQ-1:0]   req_cmd,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  cmd_valid,
  output logic [63:0]           cmd,
  input  logic                  cmd_ready,
  input  logic                  res_valid,
  input  logic [W_REWARD-1:0]   res_exp,
  input  logic [W_ACTION-1:0]   res_act,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [W_REWARD-1:0]   rsp_exp,
  output logic [W_ACTION-1:0]   rsp_act,
  output logic                  rsp_abort,
  output logic                  err_timeout,
  output logic [OwnerW-1:0]     owner,
  output logic                  busy
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [1:0] CmdRun  = 2'd0;
  localparam logic [1:0] CmdRsvd = 2'd3;

  typedef enum logic [1:0] {StIdle, StSession, StWait} state_e;

  state_e              state_q;
  logic [OwnerW-1:0]   owner_q;
  logic [OwnerW-1:0]   last_owner_q;
  logic                cmd_valid_q;
  logic [63:0]         cmd_q;
  logic [HoldW-1:0]    hold_q;
  logic                run_sent_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [W_REWARD-1:0] rsp_exp_q;
  logic [W_ACTION-1:0] rsp_act_q;
  logic                rsp_abort_q;

  logic                grant_found;
  logic [OwnerW-1:0]   grant_idx;
  logic [OwnerW:0]     rr_sum;
  logic [63:0]         owner_cmd;
  logic                cmd_free;
  logic                owner_acc;

`ifdef TREEVAL_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q;
  logic           err_timeout_q;
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Round-robin: scan from last_owner+1, wrapping at N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      rr_sum = {1'b0, last_owner_q} + (OwnerW + 1)'(k);
      if (rr_sum >= (OwnerW + 1)'(N_REQ)) begin
        rr_sum = rr_sum - (OwnerW + 1)'(N_REQ);
      end
      if (!grant_found && req_valid[rr_sum[OwnerW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = rr_sum[OwnerW-1:0];
      end
    end
  end

  always_comb begin
    owner_cmd = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == OwnerW'(i)) begin
        owner_cmd = req_cmd[64*i +: 64];
      end
    end
  end

  // The output register can take a new beat when empty or draining this cycle.
  assign cmd_free  = !cmd_valid_q || cmd_ready;
  assign owner_acc = (state_q == StSession) && req_valid[owner_q] && cmd_free;

  always_comb begin
    req_ready = '0;
    if (state_q == StSession) begin
      req_ready[owner_q] = cmd_free;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= OwnerW'(N_REQ - 1);
      cmd_valid_q  <= 1'b0;
      cmd_q        <= '0;
      hold_q       <= '0;
      run_sent_q   <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_exp_q    <= '0;
      rsp_act_q    <= '0;
      rsp_abort_q  <= 1'b0;
`ifdef TREEVAL_ARB_TIMEOUT_EN
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= '0;
      rsp_abort_q <= 1'b0;
`ifdef TREEVAL_ARB_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
      if (cmd_valid_q && cmd_ready) begin
        cmd_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            owner_q <= grant_idx;
            hold_q  <= '0;
            state_q <= StSession;
          end
        end

        StSession: begin
          if (owner_acc && owner_cmd[63:62] != CmdRsvd) begin
            cmd_valid_q <= 1'b1;
            cmd_q       <= owner_cmd;
          end
          if (owner_acc && owner_cmd[63:62] == CmdRun) begin
            run_sent_q <= 1'b0;
            hold_q     <= '0;
`ifdef TREEVAL_ARB_TIMEOUT_EN
            wd_q       <= '0;
`endif
            state_q    <= StWait;
          end else if (req_valid[owner_q]) begin
            hold_q <= '0;
          end else if (!cmd_valid_q) begin
            // Idle owner with nothing in flight: release once the hold expires.
            if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
              hold_q       <= '0;
              rsp_abort_q  <= 1'b1;
              last_owner_q <= owner_q;
              state_q      <= StIdle;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end

        StWait: begin
          if (cmd_valid_q && cmd_ready) begin
            run_sent_q <= 1'b1;
          end
          // Results count only once the RUN has left the output register.
          if (run_sent_q && res_valid) begin
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_exp_q            <= res_exp;
            rsp_act_q            <= res_act;
            last_owner_q         <= owner_q;
            state_q              <= StIdle;
          end
`ifdef TREEVAL_ARB_TIMEOUT_EN
          else if (run_sent_q) begin
            if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
              rsp_valid_q[owner_q] <= 1'b1;
              err_timeout_q        <= 1'b1;
              rsp_exp_q            <= '0;
              rsp_act_q            <= '0;
              last_owner_q         <= owner_q;
              state_q              <= StIdle;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
`endif
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_exp   = rsp_exp_q;
  assign rsp_act   = rsp_act_q;
  assign rsp_abort = rsp_abort_q;
  assign owner     = owner_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_treeval_cmd_arbiter.sv
// Directed scoreboard bench for treeval_cmd_arbiter (4 requesters).
module tb_treeval_cmd_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [255:0]  req_cmd = '0;
  logic [3:0]    req_ready;
  logic          cmd_valid;
  logic [63:0]   cmd;
  logic          cmd_ready = 1'b1;
  logic          res_valid = 1'b0;
  logic [9:0]    res_exp = '0;
  logic [2:0]    res_act = '0;
  logic [3:0]    rsp_valid;
  logic [9:0]    rsp_exp;
  logic [2:0]    rsp_act;
  logic          rsp_abort;
  logic          err_timeout;
  logic [1:0]    owner;
  logic          busy;

  always #5 clk = ~clk;

  treeval_cmd_arbiter #(
    .N_REQ(4), .W_REWARD(10), .W_ACTION(3), .HOLD_CYCLES(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .res_valid(res_valid),
    .res_exp(res_exp), .res_act(res_act), .rsp_valid(rsp_valid), .rsp_exp(rsp_exp),
    .rsp_act(rsp_act), .rsp_abort(rsp_abort), .err_timeout(err_timeout), .owner(owner),
    .busy(busy)
  );

  typedef struct packed {
    logic [3:0] v;
    logic [9:0] e;
    logic [2:0] a;
    logic       ab;
    logic       to;
  } rsp_t;

  logic [63:0] exp_cmd[$];
  rsp_t        exp_rsp[$];
  int          beat_cyc[$];
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  rsp_t        mon_r;
  logic [63:0] mon_c;
  logic [63:0] rc;
  int          k;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Call at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int r, input logic [63:0] c);
    bit hs = 1'b0;
    int n = 0;
    req_valid[r] = 1'b1;
    req_cmd[64*r +: 64] = c;
    while (!hs && n < 100) begin
      #4;
      hs = req_ready[r];
      if (hs && c[63:62] != 2'd3) exp_cmd.push_back(c);
      @(negedge clk);
      n++;
    end
    chk("req_handshake", 64'(hs), 64'd1);
  endtask

  task automatic wait_run(output logic [63:0] c);
    bit seen = 1'b0;
    int n = 0;
    c = '0;
    while (!seen && n < 100) begin
      #4;
      if (cmd_valid && cmd_ready && cmd[63:62] == 2'd0) begin
        seen = 1'b1;
        c = cmd;
      end
      @(negedge clk);
      n++;
    end
    chk("run_beat_seen", 64'(seen), 64'd1);
  endtask

  task automatic respond(input logic [3:0] oh, input logic [9:0] ev, input logic [2:0] av);
    exp_rsp.push_back('{v: oh, e: ev, a: av, ab: 1'b0, to: 1'b0});
    res_valid = 1'b1;
    res_exp = ev;
    res_act = av;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  // Output monitor: samples just before each rising edge.
  always @(negedge clk) begin
    #4;
    cyc++;
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        beat_cyc.push_back(cyc);
        chk("cmd_pending", 64'(exp_cmd.size() != 0), 64'd1);
        if (exp_cmd.size() != 0) begin
          mon_c = exp_cmd.pop_front();
          chk("cmd_beat", cmd, mon_c);
        end
      end
      if (rsp_valid != 4'b0 || rsp_abort) begin
        chk("rsp_pending", 64'(exp_rsp.size() != 0), 64'd1);
        if (exp_rsp.size() != 0) begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(mon_r.v));
          chk("rsp_abort", 64'(rsp_abort), 64'(mon_r.ab));
          chk("rsp_err_timeout", 64'(err_timeout), 64'(mon_r.to));
          if (mon_r.v != 4'b0) begin
            chk("rsp_exp", 64'(rsp_exp), 64'(mon_r.e));
            chk("rsp_act", 64'(rsp_act), 64'(mon_r.a));
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #4;
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_abort", 64'(rsp_abort), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester, full throughput, result routed to requester 1.
    beat_cyc.delete();
    send(1, 64'h4000_0000_0000_0005);
    send(1, 64'h8000_0000_0000_0011);
    send(1, 64'h0000_0000_0000_0001);
    req_valid[1] = 1'b0;
    wait_run(rc);
    respond(4'b0010, 10'h3FD, 3'd2);
    #4;
    chk("t1_busy_after_rsp", 64'(busy), 64'd0);
    chk("t1_beat_count", 64'(beat_cyc.size()), 64'd3);
    if (beat_cyc.size() >= 3) begin
      chk("t1_beat_gap0", 64'(beat_cyc[1] - beat_cyc[0]), 64'd1);
      chk("t1_beat_gap1", 64'(beat_cyc[2] - beat_cyc[1]), 64'd1);
    end
    @(negedge clk);

    // Contention from reset: sessions 0,1,2,3 without interleaving.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fork
      begin send(0, 64'h4000_0000_0000_0A00); send(0, 64'h0000_0000_0000_0B00); req_valid[0] = 1'b0; end
      begin send(1, 64'h4000_0000_0000_0A01); send(1, 64'h0000_0000_0000_0B01); req_valid[1] = 1'b0; end
      begin send(2, 64'h4000_0000_0000_0A02); send(2, 64'h0000_0000_0000_0B02); req_valid[2] = 1'b0; end
      begin send(3, 64'h4000_0000_0000_0A03); send(3, 64'h0000_0000_0000_0B03); req_valid[3] = 1'b0; end
      begin
        for (int i = 0; i < 4; i++) begin
          wait_run(rc);
          chk("t2_session_order", 64'(rc[1:0]), 64'(i));
          respond(4'b0001 << rc[1:0], 10'h3FF - {8'b0, rc[1:0]}, {1'b1, rc[1:0]});
        end
      end
    join
    repeat (2) @(negedge clk);

    // Backpressure: stalled beat stays put, owner ready low, nothing lost.
    cmd_ready = 1'b0;
    fork
      begin
        send(0, 64'h4000_0000_0000_00A1);
        send(0, 64'h4000_0000_0000_00B2);
        send(0, 64'h8000_0000_0000_00C3);
        send(0, 64'h0000_0000_0000_00D4);
        req_valid[0] = 1'b0;
      end
      begin
        bit up = 1'b0;
        int n = 0;
        while (!up && n < 50) begin
          #4;
          up = cmd_valid;
          @(negedge clk);
          n++;
        end
        chk("t3_stall_start", 64'(up), 64'd1);
        for (int i = 0; i < 5; i++) begin
          #4;
          chk("t3_cmd_stable", cmd, 64'h4000_0000_0000_00A1);
          chk("t3_ready_low", 64'(req_ready[0]), 64'd0);
          @(negedge clk);
        end
        cmd_ready = 1'b1;
      end
    join
    wait_run(rc);
    respond(4'b0001, 10'h005, 3'd7);

    // Abandon: requester 1 goes quiet, requester 2 wins over 0 next.
    req_valid[0] = 1'b1;
    req_cmd[63:0] = 64'h4000_0000_0000_0C00;
    send(1, 64'h4000_0000_0000_0C01);
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b1;
    req_cmd[191:128] = 64'hC000_0000_0000_0C02;
    exp_rsp.push_back('{v: 4'b0, e: 10'b0, a: 3'b0, ab: 1'b1, to: 1'b0});
    k = 0;
    do begin
      @(negedge clk);
      k++;
      #4;
    end while (!rsp_abort && k < 60);
    chk("t4_abort_latency", 64'(k), 64'd17);
    chk("t4_busy_low", 64'(busy), 64'd0);
    @(negedge clk);
    #4;
    chk("t4_next_owner", 64'(owner), 64'd2);
    chk("t4_busy_high", 64'(busy), 64'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;

    // Reserved type is swallowed; reset while waiting drops everything.
    send(2, 64'hC000_0000_0000_0D02);
    send(2, 64'h0000_0000_0000_0E02);
    req_valid[2] = 1'b0;
    wait_run(rc);
    rst = 1'b1;
    @(negedge clk);
    #4;
    chk("t5_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_owner", 64'(owner), 64'd0);
    chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rst_rsp_abort", 64'(rsp_abort), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    res_valid = 1'b1;
    res_exp = 10'h1AB;
    @(negedge clk);
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    chk("t5_idle_res_ignored", 64'(rsp_valid), 64'd0);
    chk("t5_idle_busy", 64'(busy), 64'd0);
    @(negedge clk);

`ifdef TREEVAL_ARB_TIMEOUT_EN
    send(3, 64'h0000_0000_0000_0F03);
    req_valid[3] = 1'b0;
    wait_run(rc);
    exp_rsp.push_back('{v: 4'b1000, e: 10'b0, a: 3'b0, ab: 1'b0, to: 1'b1});
    repeat (12) @(negedge clk);
    #4;
    chk("t6_idle_after_timeout", 64'(busy), 64'd0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
